// File: rtl/bazz_sched.sv
// Buzzer sequencer: edge-detected game events are queued and played as beeps.
// Optional BAZZ_PREEMPT_EN lets a higher-priority pending event abort the one playing.
module bazz_sched #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned HALF_HIT   = 25000,
  parameter int unsigned HALF_WALL  = 50000,
  parameter int unsigned HALF_FELL  = 100000,
  parameter int unsigned DUR_HIT    = 50,
  parameter int unsigned DUR_WALL   = 30,
  parameter int unsigned DUR_FELL   = 150,
  parameter int unsigned GAP_TICKS  = 20,
  parameter int unsigned BEEPS_FELL = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev_hit,
  input  logic       ev_wall,
  input  logic       ev_fell,
  output logic       buzz_n,
  output logic       busy,
  output logic [1:0] cur_ev,
  output logic       done
);

  localparam int unsigned HALF_HW  = (HALF_HIT > HALF_WALL) ? HALF_HIT : HALF_WALL;
  localparam int unsigned HALF_MAX = (HALF_HW > HALF_FELL) ? HALF_HW : HALF_FELL;
  localparam int unsigned DUR_HW   = (DUR_HIT > DUR_WALL) ? DUR_HIT : DUR_WALL;
  localparam int unsigned DUR_MAX  = (DUR_HW > DUR_FELL) ? DUR_HW : DUR_FELL;
  localparam int unsigned TCK_MAX  = (DUR_MAX > GAP_TICKS) ? DUR_MAX : GAP_TICKS;

  localparam int unsigned PW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int unsigned HW = (HALF_MAX > 1)   ? $clog2(HALF_MAX)   : 1;
  localparam int unsigned TW = (TCK_MAX > 1)    ? $clog2(TCK_MAX)    : 1;
  localparam int unsigned BW = (BEEPS_FELL > 1) ? $clog2(BEEPS_FELL) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HL_HIT     = HW'(HALF_HIT - 1);
  localparam logic [HW-1:0] HL_WALL    = HW'(HALF_WALL - 1);
  localparam logic [HW-1:0] HL_FELL    = HW'(HALF_FELL - 1);
  localparam logic [TW-1:0] DL_HIT     = TW'(DUR_HIT - 1);
  localparam logic [TW-1:0] DL_WALL    = TW'(DUR_WALL - 1);
  localparam logic [TW-1:0] DL_FELL    = TW'(DUR_FELL - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
  localparam logic [BW-1:0] FELL_LAST  = BW'((BEEPS_FELL == 0) ? 0 : BEEPS_FELL - 1);
  localparam bit            HAS_GAP    = (GAP_TICKS != 0);

  // Codes are ordered so that a numerically larger code means higher priority.
  localparam logic [1:0] EV_NONE = 2'd0;
  localparam logic [1:0] EV_WALL = 2'd1;
  localparam logic [1:0] EV_HIT  = 2'd2;
  localparam logic [1:0] EV_FELL = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t        state;
  logic [2:0]    ev_q;
  logic [2:0]    pending;
  logic [PW-1:0] presc;
  logic [HW-1:0] half_cnt;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] beep_cnt;

  logic [2:0]    ev_vec, rise, grant_mask;
  logic [1:0]    pend_code;
  logic [HW-1:0] half_last;
  logic [TW-1:0] dur_last;
  logic [BW-1:0] beep_last;
  logic          preempt, tick, beep_end, gap_end, last_beep;
  logic          ev_start, to_gap, svc_end, to_idle, rebeep, restart;

  always_comb begin
    ev_vec    = {ev_fell, ev_hit, ev_wall};
    rise      = ev_vec & ~ev_q;
    half_last = '0;
    dur_last  = '0;
    beep_last = '0;
    case (cur_ev)
      EV_WALL: begin half_last = HL_WALL; dur_last = DL_WALL; end
      EV_HIT:  begin half_last = HL_HIT;  dur_last = DL_HIT;  end
      EV_FELL: begin half_last = HL_FELL; dur_last = DL_FELL; beep_last = FELL_LAST; end
      default: ;
    endcase

    if (pending[2])      pend_code = EV_FELL;
    else if (pending[1]) pend_code = EV_HIT;
    else if (pending[0]) pend_code = EV_WALL;
    else                 pend_code = EV_NONE;

`ifdef BAZZ_PREEMPT_EN
    preempt = (state != S_IDLE) && (pend_code > cur_ev);
`else
    preempt = 1'b0;
`endif

    tick      = (presc == PRESC_LAST);
    beep_end  = (state == S_PLAY) && tick && (tick_cnt == dur_last);
    gap_end   = (state == S_GAP) && tick && (tick_cnt == GAP_LAST);
    last_beep = (beep_cnt == beep_last);
    ev_start  = ((state == S_IDLE) && (pending != '0)) || preempt;
    // With no gap configured a finished beep goes straight to the next beep or to IDLE.
    to_gap    = !ev_start && beep_end && HAS_GAP;
    svc_end   = !ev_start && (gap_end || (beep_end && !HAS_GAP));
    to_idle   = svc_end && last_beep;
    rebeep    = svc_end && !last_beep;
    restart   = ev_start || rebeep || to_gap || to_idle;

    grant_mask = '0;
    if (ev_start) begin
      case (pend_code)
        EV_FELL: grant_mask = 3'b100;
        EV_HIT:  grant_mask = 3'b010;
        EV_WALL: grant_mask = 3'b001;
        default: grant_mask = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ev_q     <= '0;
      pending  <= '0;
      presc    <= '0;
      half_cnt <= '0;
      tick_cnt <= '0;
      beep_cnt <= '0;
      buzz_n   <= 1'b1;
      busy     <= 1'b0;
      cur_ev   <= EV_NONE;
      done     <= 1'b0;
    end else begin
      ev_q    <= ev_vec;
      // A re-edge on the cycle its bit is granted keeps the bit set.
      pending <= (pending & ~grant_mask) | rise;
      done    <= to_idle;

      if (restart || state == S_IDLE) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) tick_cnt <= tick_cnt + 1'b1;
      end

      if (state == S_PLAY && !restart) begin
        if (half_cnt == half_last) begin
          half_cnt <= '0;
          buzz_n   <= ~buzz_n;
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
      end else begin
        half_cnt <= '0;
      end

      if (ev_start) begin
        state    <= S_PLAY;
        cur_ev   <= pend_code;
        busy     <= 1'b1;
        buzz_n   <= 1'b0;
        beep_cnt <= '0;
      end else if (rebeep) begin
        state    <= S_PLAY;
        buzz_n   <= 1'b0;
        beep_cnt <= beep_cnt + 1'b1;
      end else if (to_gap) begin
        state    <= S_GAP;
        buzz_n   <= 1'b1;
      end else if (to_idle) begin
        state    <= S_IDLE;
        buzz_n   <= 1'b1;
        busy     <= 1'b0;
        cur_ev   <= EV_NONE;
        beep_cnt <= '0;
      end
    end
  end

endmodule
